// File: rtl/instr_encoder.sv
// Instruction encoder: turns encode requests into 32-bit MIPS-style words.
// Legal requests are queued in a 4-deep FIFO. A two-state write FSM then
// drains the FIFO into instruction memory at consecutive word addresses.
module instr_encoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] base_addr_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    output logic [15:0] instr_count_o,
    output logic        err_o
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [2:0] KIND_R       = 3'd0;
    localparam logic [2:0] KIND_BEQ     = 3'd1;
    localparam logic [2:0] KIND_ADDI    = 3'd2;
    localparam logic [2:0] KIND_SLTIU   = 3'd3;
    localparam logic [2:0] KIND_LUI     = 3'd4;
    localparam logic [2:0] KIND_ORI     = 3'd5;
    localparam logic [2:0] KIND_BNE     = 3'd6;
    localparam logic [2:0] KIND_ILLEGAL = 3'd7;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Build one instruction word from the request fields.
    // lui has no source register, so its rs field is forced to zero.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [5:0] opc;
        logic [4:0] rs_f;
        opc  = OP_R;
        rs_f = rs;
        case (kind)
            KIND_BEQ:   opc = OP_BEQ;
            KIND_ADDI:  opc = OP_ADDI;
            KIND_SLTIU: opc = OP_SLTIU;
            KIND_LUI: begin
                opc  = OP_LUI;
                rs_f = 5'd0;
            end
            KIND_ORI:   opc = OP_ORI;
            KIND_BNE:   opc = OP_BNE;
            default:    opc = OP_R;
        endcase
        if (kind == KIND_R)
            encode = {OP_R, rs, rt, rd, shamt, funct};
        else
            encode = {opc, rs_f, rt, imm};
    endfunction

    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;
    logic [31:0] addr_q;
    state_t      state;
    logic [31:0] enc_word;
    logic        hs;
    logic        push;
    logic        pop;

    assign enc_word = encode(kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i);

    // Readiness uses this cycle's occupancy only. A pop in the same
    // cycle does not open a slot for a push.
    assign req_ready_o = !rst_i && (fifo_cnt != 3'd4);
    assign hs          = req_valid_i && req_ready_o;
    assign push        = hs && (kind_i != KIND_ILLEGAL);
    assign pop         = (state == WRITE) && mem_ack_i;
    assign mem_addr_o  = addr_q;

    // FIFO storage holds only data. Stale entries are unreachable after a reset.
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= enc_word;
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky error flag: an illegal kind is consumed and never queued.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_o <= 1'b0;
        else if (hs && (kind_i == KIND_ILLEGAL))
            err_o <= 1'b1;
    end

    // Write FSM. It presents the FIFO head and holds address and data until the memory acknowledges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            mem_we_o      <= 1'b0;
            mem_data_o    <= 32'd0;
            addr_q        <= base_addr_i;
            instr_count_o <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_cnt != 3'd0) begin
                        state      <= WRITE;
                        mem_we_o   <= 1'b1;
                        mem_data_o <= fifo_mem[rd_ptr];
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        state         <= IDLE;
                        mem_we_o      <= 1'b0;
                        addr_q        <= addr_q + 32'd4;
                        instr_count_o <= instr_count_o + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 base_addr_i  input  32  first write address, sampled only while rst_i=1.
REQ-005 req_valid_i  input  1  encode request present.
REQ-006 req_ready_o  output  1  block can accept a request this cycle.
REQ-007 kind_i  input  3  instruction kind: 0=R, 1=beq, 2=addi, 3=sltiu, 4=lui, 5=ori, 6=bne, 7=illegal.
REQ-008 rs_i / rt_i / rd_i / shamt_i  input  5 each  register and shift fields.
REQ-009 funct_i  input  6  R-type function field.
REQ-010 imm_i  input  16  immediate or branch word offset.
REQ-011 mem_we_o  output  1  instruction-memory write strobe.
REQ-012 mem_addr_o  output  32  byte address of the current write.
REQ-013 mem_data_o  output  32  encoded instruction word.
REQ-014 mem_ack_i  input  1  memory accepted the current write.
REQ-015 instr_count_o  output  16  number of words written since reset.
REQ-016 err_o  output  1  sticky illegal-kind flag.

Function
REQ-017 Opcodes SHALL be R=6'b000000, beq=6'b000100, bne=6'b000101, addi=6'b001000, sltiu=6'b001011, ori=6'b001101, lui=6'b001111.
REQ-018 The R-type word SHALL be {opcode, rs_i, rt_i, rd_i, shamt_i, funct_i}.
REQ-019 The I-type word (kinds 1-6) SHALL be {opcode, rs, rt_i, imm_i}, where rs=rs_i except for lui, where rs is forced to 5'd0.
REQ-020 Encoding SHALL be combinational at the input; the 32-bit result is pushed into a 4-entry FIFO on a handshake cycle.
REQ-021 A handshake SHALL occur when req_valid_i=1 and req_ready_o=1 at a rising edge.
REQ-022 req_ready_o SHALL equal NOT(FIFO full), using the current-cycle occupancy; a pop in the same cycle does not free a slot for a push.
REQ-023 A handshake with kind_i=7 SHALL consume the request, push nothing and set err_o=1 until reset.
REQ-024 The write FSM SHALL have two states, IDLE and WRITE.
REQ-025 In IDLE with the FIFO non-empty, the FSM SHALL move to WRITE at the next edge; otherwise it stays in IDLE.
REQ-026 In WRITE, mem_we_o SHALL be 1 and mem_data_o SHALL be the FIFO head; mem_addr_o and mem_data_o SHALL stay stable until mem_ack_i=1.
REQ-027 On a WRITE edge with mem_ack_i=1, the block SHALL pop the FIFO, add 4 to the address register, increment instr_count_o and return to IDLE.
REQ-028 In IDLE, mem_we_o SHALL be 0; mem_ack_i SHALL be ignored outside WRITE.
REQ-029 Latency: for a push at edge N into an empty FIFO while in IDLE, mem_we_o SHALL be 1 in the cycle after edge N+1, and the minimum throughput is one word per 2 cycles.
REQ-030 A simultaneous push and pop SHALL both occur; occupancy is unchanged and FIFO order is preserved.
REQ-031 The address SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-032 instr_count_o SHALL wrap from 16'hFFFF to 0.

Reset
REQ-033 On rst_i=1 at an edge, the block SHALL set: FSM=IDLE, FIFO empty, mem_we_o=0, mem_data_o=0, address register=base_addr_i, instr_count_o=0, err_o=0.
REQ-034 Reset asserted mid-WRITE SHALL abort the write; pending FIFO words are discarded and no ack is expected afterwards.
REQ-035 While rst_i=1, req_ready_o SHALL be 0.

Verification
REQ-036 base=0x0000_0400; addi rs=1 rt=2 imm=0x0005; ack held 1 -> one write of 0x20220005 at addr 0x400, instr_count_o=1.
REQ-037 R-type with rs=1, rt=2, rd=3, shamt=0, funct=0x20, followed by bne with rs=1, rt=2, imm=0xFFFE -> writes 0x00221820 @0x400, then 0x1422FFFE @0x404, in order.
REQ-038 lui rs_i=7 rt=4 imm=0x1234 -> mem_data_o=0x3C041234 (rs field zero).
REQ-039 ack held 0; push 5 valid requests back-to-back -> 4 accepted, then req_ready_o=0 and the 5th stays pending; mem_we_o/addr/data stay stable; releasing ack drains the FIFO in order and then accepts the 5th.
REQ-040 kind=7 request -> err_o=1 from the next cycle, no mem_we_o, count unchanged; a following valid ori is still encoded (0x34xxxxxx).
REQ-041 rst_i pulsed during WRITE with base=0xFFFF_FFFC -> outputs return to reset values; the next write goes to 0xFFFF_FFFC and the one after goes to 0x0000_0000.
